// File: rtl/hwt_pkg.sv
// Shared types and default parameters for observers of the hwt trigger cell.
package hwt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RUN     = 2'd2,
    ST_TRIPPED = 2'd3
  } hwt_state_t;

  localparam int HWT_RUN_THRESH = 4;
  localparam int HWT_RUN_W      = 8;
  localparam int HWT_EVT_W      = 16;

endpackage

// File: rtl/hwt_monitor_if.sv
// Control and observation bundle between the hwt_monitor and its test/observation logic.
interface hwt_monitor_if
  import hwt_pkg::*;
#(
  parameter int RUN_W = HWT_RUN_W,
  parameter int EVT_W = HWT_EVT_W
);

  logic             en;
  logic             y_in;
  logic             clear;
  logic             alarm;
  logic [1:0]       state_o;
  logic [RUN_W-1:0] run_len;
  logic [EVT_W-1:0] event_cnt;

  modport master (
    output en, y_in, clear,
    input  alarm, state_o, run_len, event_cnt
  );

  modport slave (
    input  en, y_in, clear,
    output alarm, state_o, run_len, event_cnt
  );

endinterface

// File: rtl/hwt_edge_sync.sv
// Samples the (possibly glitchy) hwt Y output at the clock edge and flags sampled rising edges.
module hwt_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic y_in,
  output logic y_q,
  output logic rise
);

  logic y_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= 1'b0;
      y_d <= 1'b0;
    end else begin
      y_q <= y_in;
      y_d <= y_q;
    end
  end

  assign rise = y_q & ~y_d;

endmodule

// File: rtl/hwt_monitor.sv
// Run-length / edge-count monitor with a sticky alarm, fed by the hwt trigger output.
//   state      | meaning
//   ST_IDLE    | disarmed, run_len held at 0
//   ST_ARMED   | armed, waiting for a sampled high
//   ST_RUN     | counting consecutive high samples
//   ST_TRIPPED | run reached RUN_THRESH; alarm held until clear
module hwt_monitor
  import hwt_pkg::*;
#(
  parameter int RUN_THRESH = HWT_RUN_THRESH,
  parameter int RUN_W      = HWT_RUN_W,
  parameter int EVT_W      = HWT_EVT_W
) (
  input logic          clk,
  input logic          rst,
  hwt_monitor_if.slave mon
);

  localparam logic [RUN_W-1:0] THRESH  = RUN_W'(RUN_THRESH);
  localparam logic [EVT_W-1:0] EVT_MAX = '1;

  // run_len must be able to hold RUN_THRESH without wrapping
  if (RUN_THRESH < 1 || (RUN_THRESH >> RUN_W) != 0) begin : g_thresh_range
    $error("hwt_monitor: RUN_THRESH out of range 1 .. 2**RUN_W-1");
  end

  hwt_state_t       state;
  logic [RUN_W-1:0] run_len;
  logic [RUN_W-1:0] run_nxt;
  logic [EVT_W-1:0] event_cnt;
  logic             alarm;
  logic             y_q;
  logic             rise;

  hwt_edge_sync u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .y_in (mon.y_in),
    .y_q  (y_q),
    .rise (rise)
  );

  assign run_nxt = run_len + RUN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      run_len   <= '0;
      event_cnt <= '0;
      alarm     <= 1'b0;
    end else begin
      if (mon.clear) begin
        event_cnt <= '0;
      end else if (rise && state != ST_IDLE && event_cnt != EVT_MAX) begin
        event_cnt <= event_cnt + EVT_W'(1);
      end

      if (mon.clear) begin
        run_len <= '0;
        if (state == ST_TRIPPED) begin
          state <= mon.en ? ST_ARMED : ST_IDLE;
          alarm <= 1'b0;
        end else if (state == ST_RUN) begin
          state <= ST_ARMED;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            run_len <= '0;
            if (mon.en) state <= ST_ARMED;
          end
          ST_ARMED: begin
            if (!mon.en) begin
              state <= ST_IDLE;
            end else if (y_q) begin
              run_len <= RUN_W'(1);
              if (RUN_THRESH == 1) begin
                state <= ST_TRIPPED;
                alarm <= 1'b1;
              end else begin
                state <= ST_RUN;
              end
            end
          end
          ST_RUN: begin
            if (!mon.en) begin
              state   <= ST_IDLE;
              run_len <= '0;
            end else if (!y_q) begin
              state   <= ST_ARMED;
              run_len <= '0;
            end else begin
              run_len <= run_nxt;
              if (run_nxt == THRESH) begin
                state <= ST_TRIPPED;
                alarm <= 1'b1;
              end
            end
          end
          ST_TRIPPED: ;
          default: begin
            state   <= ST_IDLE;
            run_len <= '0;
            alarm   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mon.alarm     = alarm;
  assign mon.state_o   = state;
  assign mon.run_len   = run_len;
  assign mon.event_cnt = event_cnt;

endmodule

// File: tb/tb_hwt_monitor.sv
// Bench for hwt_monitor: three parameterisations driven by shared stimulus.
module tb_hwt_monitor;

  logic clk = 1'b0;
  logic rst, en, y_in, clear;

  always #5 clk = ~clk;

  hwt_monitor_if #(.RUN_W(8), .EVT_W(16)) if0 ();
  hwt_monitor_if #(.RUN_W(8), .EVT_W(3))  if1 ();
  hwt_monitor_if #(.RUN_W(8), .EVT_W(16)) if2 ();

  assign if0.en = en;  assign if0.y_in = y_in;  assign if0.clear = clear;
  assign if1.en = en;  assign if1.y_in = y_in;  assign if1.clear = clear;
  assign if2.en = en;  assign if2.y_in = y_in;  assign if2.clear = clear;

  hwt_monitor #(.RUN_THRESH(4), .RUN_W(8), .EVT_W(16)) dut0 (.clk(clk), .rst(rst), .mon(if0));
  hwt_monitor #(.RUN_THRESH(4), .RUN_W(8), .EVT_W(3))  dut1 (.clk(clk), .rst(rst), .mon(if1));
  hwt_monitor #(.RUN_THRESH(1), .RUN_W(8), .EVT_W(16)) dut2 (.clk(clk), .rst(rst), .mon(if2));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: sampled-input history plus run/event bookkeeping per instance.
  int thr  [3] = '{4, 4, 1};
  int emax [3] = '{65535, 7, 65535};
  int m_q  [3], m_d [3], m_st [3], m_run [3], m_evt [3];

  task automatic model_step(input int i);
    bit r;
    r = (m_q[i] == 1) && (m_d[i] == 0);
    if (rst) begin
      m_q[i] = 0; m_d[i] = 0; m_st[i] = 0; m_run[i] = 0; m_evt[i] = 0;
      return;
    end
    if (clear)                 m_evt[i] = 0;
    else if (r && m_st[i] != 0) m_evt[i] = (m_evt[i] + 1 > emax[i]) ? emax[i] : m_evt[i] + 1;
    if (clear) begin
      m_run[i] = 0;
      if (m_st[i] == 3)      m_st[i] = en ? 1 : 0;
      else if (m_st[i] == 2) m_st[i] = 1;
    end else if (m_st[i] == 3) begin
    end else if (!en) begin
      m_st[i] = 0; m_run[i] = 0;
    end else if (m_st[i] == 0) begin
      m_st[i] = 1;
    end else if (m_q[i] == 1) begin
      m_run[i] = m_run[i] + 1;
      m_st[i]  = (m_run[i] >= thr[i]) ? 3 : 2;
    end else begin
      m_run[i] = 0; m_st[i] = 1;
    end
    m_d[i] = m_q[i];
    m_q[i] = int'(y_in);
  endtask

  task automatic step();
    for (int i = 0; i < 3; i++) model_step(i);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_dut(input int i, input string tag, input int est, input int erun,
                         input int eal, input int eevt);
    logic [31:0] st, rn, al, ev;
    case (i)
      0:       begin st = 32'(if0.state_o); rn = 32'(if0.run_len); al = 32'(if0.alarm); ev = 32'(if0.event_cnt); end
      1:       begin st = 32'(if1.state_o); rn = 32'(if1.run_len); al = 32'(if1.alarm); ev = 32'(if1.event_cnt); end
      default: begin st = 32'(if2.state_o); rn = 32'(if2.run_len); al = 32'(if2.alarm); ev = 32'(if2.event_cnt); end
    endcase
    if (est  >= 0) chk($sformatf("%s d%0d state", tag, i), st, est);
    if (erun >= 0) chk($sformatf("%s d%0d run_len", tag, i), rn, erun);
    if (eal  >= 0) chk($sformatf("%s d%0d alarm", tag, i), al, eal);
    if (eevt >= 0) chk($sformatf("%s d%0d event_cnt", tag, i), ev, eevt);
  endtask

  typedef struct {
    logic r, e, y, c;
    int   st, rn, al, ev;
  } vec_t;

  function automatic vec_t mk(input logic r, e, y, c, input int st, rn, al, ev);
    vec_t v;
    v.r = r; v.e = e; v.y = y; v.c = c;
    v.st = st; v.rn = rn; v.al = al; v.ev = ev;
    return v;
  endfunction

  vec_t tv[$];

  initial begin
    rst = 1'b1; en = 1'b0; y_in = 1'b0; clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_q[i] = 0; m_d[i] = 0; m_st[i] = 0; m_run[i] = 0; m_evt[i] = 0;
    end

    // trip, sticky alarm, clear with en=0, then a broken run (1,1,1,0,1) on the THRESH=4 instance
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0));
    tv.push_back(mk(0, 1, 1, 0, 2, 1, 0, 1));
    tv.push_back(mk(0, 1, 1, 0, 2, 2, 0, 1));
    tv.push_back(mk(0, 1, 1, 0, 2, 3, 0, 1));
    tv.push_back(mk(0, 1, 1, 0, 3, 4, 1, 1));
    tv.push_back(mk(0, 0, 0, 0, 3, 4, 1, 1));
    tv.push_back(mk(0, 0, 0, 0, 3, 4, 1, 1));
    tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0));
    tv.push_back(mk(0, 1, 1, 0, 2, 1, 0, 1));
    tv.push_back(mk(0, 1, 1, 0, 2, 2, 0, 1));
    tv.push_back(mk(0, 1, 0, 0, 2, 3, 0, 1));
    tv.push_back(mk(0, 1, 1, 0, 1, 0, 0, 1));
    tv.push_back(mk(0, 1, 0, 0, 2, 1, 0, 2));
    tv.push_back(mk(0, 1, 0, 0, 1, 0, 0, 2));

    for (int k = 0; k < tv.size(); k++) begin
      rst = tv[k].r; en = tv[k].e; y_in = tv[k].y; clear = tv[k].c;
      step();
      chk_dut(0, $sformatf("vec%0d", k), tv[k].st, tv[k].rn, tv[k].al, tv[k].ev);
    end

    // RUN_THRESH=1: a single-sample pulse trips from ARMED; en=0 is ignored while tripped
    rst = 1; en = 0; y_in = 0; clear = 0; step();
    rst = 0; en = 1; step();
    y_in = 1; step();
    chk_dut(2, "thr1_pre", 1, 0, 0, 0);
    y_in = 0; step();
    chk_dut(2, "thr1_trip", 3, 1, 1, 1);
    chk_dut(0, "thr1_ref4", 2, 1, 0, 1);
    en = 0; step();
    chk_dut(2, "thr1_en0a", 3, 1, 1, 1);
    step();
    chk_dut(2, "thr1_en0b", 3, 1, 1, 1);
    chk_dut(0, "thr1_ref4_idle", 0, 0, 0, 1);

    // saturation: 10 isolated pulses while armed; EVT_W=3 stops at 7
    rst = 1; en = 0; y_in = 0; step();
    rst = 0; en = 1; step();
    for (int p = 0; p < 10; p++) begin
      y_in = 1; step();
      y_in = 0; step(); step(); step();
    end
    chk_dut(1, "sat", 1, 0, 0, 7);
    chk_dut(0, "sat", 1, 0, 0, 10);
    chk_dut(2, "sat", 3, 1, 1, 10);

    // clear in the same cycle as a rise: clear wins
    y_in = 1; step();
    y_in = 0; clear = 1; step();
    chk_dut(0, "clr_rise", 1, 0, 0, 0);
    chk_dut(1, "clr_rise", 1, 0, 0, 0);
    chk_dut(2, "clr_rise", 1, 0, 0, 0);
    clear = 0;

    // reset mid-run with y_in held high; the high is not counted until re-armed
    rst = 1; step();
    rst = 0; en = 1; y_in = 1; step(); step(); step();
    chk_dut(0, "mid_run", 2, 2, 0, 1);
    rst = 1; step();
    chk_dut(0, "mid_rst", 0, 0, 0, 0);
    rst = 0; en = 0; step(); step();
    chk_dut(0, "rst_idle", 0, 0, 0, 0);
    en = 1; step();
    chk_dut(0, "rearm", 1, 0, 0, 0);
    step();
    chk_dut(0, "rearm_run", 2, 1, 0, 0);

    // randomized traffic against the reference model
    rst = 1; en = 0; y_in = 0; clear = 0; step();
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      en    = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) y_in = ~y_in;
      step();
      for (int i = 0; i < 3; i++)
        chk_dut(i, $sformatf("rnd%0d", c), m_st[i], m_run[i], int'(m_st[i] == 3), m_evt[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hwt_monitor.md
# hwt_monitor

Sequential monitor directly downstream of the combinational `hwt` trigger cell; consumes its `Y` output.
- Registers the trigger output, counts rising edges, and measures consecutive-high run length.
- Raises a sticky `alarm` once `Y` has been high for `RUN_THRESH` consecutive samples.
- The alarm is released only by an explicit `clear`, so it gives the test/observation logic a stable, cycle-accurate record of trigger activity.

## Interface
- `RUN_THRESH`, default 4: consecutive high samples needed to trip; legal range 1 .. 2^RUN_W-1.
- `RUN_W`, default 8: width of the run-length counter.
- `EVT_W`, default 16: width of the rising-edge event counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  arm the monitor; 0 forces IDLE (except from TRIPPED).
- `y_in`  in  1  trigger output `Y` of `hwt`; may glitch and is sampled only at the edge.
- `clear`  in  1  single-cycle pulse; releases the alarm and zeroes the counters.
- `alarm`  out  1  sticky; high in TRIPPED.
- `state_o`  out  2  current FSM state encoding.
- `run_len`  out  RUN_W  current consecutive-high count.
- `event_cnt`  out  EVT_W  rising edges of the sampled `y_in` while armed.

## Operation
Input stage:
- `y_q <= y_in` every cycle.
- `y_d <= y_q`.
- `rise = y_q & ~y_d`.

FSM, states IDLE=0, ARMED=1, RUN=2, TRIPPED=3:
- **IDLE:** `run_len`=0. `en`=1 → ARMED.
- **ARMED:**
  - `en`=0 → IDLE.
  - `y_q`=1 → RUN with `run_len`=1; if `RUN_THRESH`==1, → TRIPPED directly with `run_len`=1.
- **RUN:**
  - `en`=0 → IDLE with `run_len`=0.
  - `y_q`=0 → ARMED with `run_len`=0.
  - `y_q`=1 → `run_len`+1; on reaching `RUN_THRESH` → TRIPPED.
- **TRIPPED:**
  - `alarm`=1 and `run_len` frozen at `RUN_THRESH`; `en` and `y_q` are ignored.
  - `clear` → ARMED if `en`=1, else IDLE; `run_len`=0.

`event_cnt`:
- +1 on `rise` while the state is ARMED, RUN, or TRIPPED.
- Saturates at 2^EVT_W-1; no wrap.
- `clear` zeroes it in any state.
- `clear` and `rise` in the same cycle → 0 (clear wins).

`clear` outside TRIPPED:
- Zeroes `event_cnt` and `run_len`.
- RUN → ARMED; other states unchanged.

Precedence, highest first: `rst` > `clear` > `en`=0 > `y_q` evaluation.

## Timing
- Reset values: `alarm`=0, `state_o`=IDLE (0), `run_len`=0, `event_cnt`=0. Internal `y_q`=0, `y_d`=0.
- `rst` asserted mid-run or in TRIPPED returns everything to reset values at the next edge. `en` is sampled again from the edge after `rst` deasserts.
- Sampling latency: `y_in` high before edge k → `y_q`=1 after edge k → `run_len`=1 after edge k+1.
- Trip latency: `alarm`=1 after edge k+`RUN_THRESH`, i.e. `RUN_THRESH`+1 edges from the first sampled high.
- `event_cnt` updates one edge after `y_q` rises (after edge k+1).
- `alarm` falls on the edge that samples `clear`=1.
- A high `y_q` in the cycle after `clear` starts a new run (`run_len`=1 one edge later if `en`=1).
- A single-cycle `y_in` pulse gives `run_len` 1 for one cycle, then 0; it never trips unless `RUN_THRESH`=1.
- `run_len` cannot overflow: `RUN_THRESH` ≤ 2^RUN_W-1 is checked by an elaboration-time assertion.

## Structure
- **Shared package `hwt_pkg`:**
  - state type with the encodings above;
  - default constants `HWT_RUN_THRESH`=4, `HWT_RUN_W`=8, `HWT_EVT_W`=16.
- **Sub-module `hwt_edge_sync`:** the `y_q`/`y_d` register pair plus the `rise` output; reusable by other `hwt` observers.
- **Top `hwt_monitor`:** instantiates `hwt_edge_sync` and holds the FSM, run counter, and saturating event counter.

## Test plan
- **Trip:** `rst` 2 cycles, `en`=1, `y_in`=1 from edge 3 onward, `RUN_THRESH`=4 → `run_len` 1,2,3,4 after edges 4..7; `alarm`=1 and state 3 after edge 7; `event_cnt`=1.
- **Broken run:** `y_in` pattern 1,1,1,0,1 → `run_len` returns to 0, state ARMED; `alarm` stays 0; `event_cnt`=2.
- **Sticky/clear:** trip, then drop `en` and `y_in` → `alarm` holds. Pulse `clear` with `en`=0 → `alarm`=0, state IDLE, counters 0 on that edge.
- **Saturation:** `EVT_W`=3, 10 isolated `y_in` pulses while armed → `event_cnt` stops at 7. `clear` coincident with a rise → `event_cnt`=0.
- **Reset mid-operation:** assert `rst` in RUN with `run_len`=2 → next edge all outputs 0, state IDLE; `y_in`=1 held through reset does not count until re-armed.
- **Single-sample threshold:** `RUN_THRESH`=1 → one-cycle `y_in` pulse trips directly from ARMED with `run_len`=1; `en`=0 during TRIPPED has no effect.
